mdiv_seq: RTL and testbench

Iterative, multi-cycle mantissa divider controller for the FP divide path. It sequences a radix-2 restoring division, one quotient bit per cycle, and replaces the single-cycle combinational mantissa divider where area matters. It computes the same function: quotient of 1.m1 / 1.m2, a normalized result mantissa, and an exponent-decrement flag. Valid/ready handshakes sit on both sides so the FP divide control can stall it.

---
 rtl/mdiv_seq.sv | 105 ++++++++++
 tb/tb_mdiv_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdiv_seq.sv
// Radix-2 restoring mantissa divider: one quotient bit per clock, valid/ready on both sides.
// Produces the normalized quotient fraction of 1.m1 / 1.m2 and an exponent-decrement flag.
module mdiv_seq #(
    parameter int WIDTH = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] m1,
    input  logic [WIDTH-1:0] m2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] m3,
    output logic             decrement_exponent,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH:0]   div_q;
    logic [WIDTH+1:0] rem_q;
    logic [WIDTH:0]   quo_q;
    logic [CW-1:0]    cnt_q;

    logic             q_bit;
    logic [WIDTH+1:0] rem_sub;
    logic [WIDTH+1:0] rem_nx;
    logic [WIDTH:0]   quo_nx;

    // One restoring step; R stays below 2*D so WIDTH+2 bits never overflow.
    always_comb begin
        q_bit   = (rem_q >= {1'b0, div_q});
        rem_sub = q_bit ? (rem_q - {1'b0, div_q}) : rem_q;
        rem_nx  = rem_sub << 1;
        quo_nx  = {quo_q[WIDTH-1:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = CALC;
            end
            CALC: begin
                if (cnt_q == '0) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q              <= '0;
            rem_q              <= '0;
            quo_q              <= '0;
            cnt_q              <= '0;
            m3                 <= '0;
            decrement_exponent <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        div_q <= {1'b1, m2};
                        rem_q <= {2'b01, m1};
                        quo_q <= '0;
                        cnt_q <= CW'(WIDTH);
                    end
                end
                CALC: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    if (cnt_q == '0) begin
                        // Quotient below 1.0 loses its leading one; renormalize by one place.
                        decrement_exponent <= ~quo_nx[WIDTH];
                        m3 <= quo_nx[WIDTH] ? quo_nx[WIDTH-1:0]
                                            : {quo_nx[WIDTH-2:0], 1'b0};
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdiv_seq.sv
// Randomized and directed bench for mdiv_seq; results checked against a plain-arithmetic
// division model through an in-order scoreboard.
module tb_mdiv_seq;
    localparam int W  = 23;
    localparam int NR = 1500;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] m1 = '0;
    logic [W-1:0] m2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] m3;
    logic         decrement_exponent;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_acc   = 0;
    int n_res   = 0;
    bit rnd_done = 1'b0;

    typedef struct {
        logic [W-1:0] m3;
        logic         dec;
        int           t;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         e;
    logic         prev_ov = 1'b0;
    logic         prev_taken = 1'b0;
    logic         prev_dec = 1'b0;
    logic [W-1:0] prev_m3 = '0;

    mdiv_seq #(.WIDTH(W)) dut (
        .clk                (clk),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .m1                 (m1),
        .m2                 (m2),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .m3                 (m3),
        .decrement_exponent (decrement_exponent),
        .busy               (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: integer division of the scaled mantissas, then normalize.
    function automatic logic [W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned num, den, q;
        logic d;
        num = 64'({1'b1, a}) << W;
        den = 64'({1'b1, b});
        q   = num / den;
        d   = (q < (64'd1 << W));
        return {d, d ? W'(q << 1) : W'(q)};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: condition not met, got timeout/violation, expected normal completion", name);
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        m1 = a;
        m2 = b;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready && !reset;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        m1 = W'($urandom);
        m2 = W'($urandom);
        if (!ok) fail_now("accept_timeout");
    endtask

    // Returns on the negedge where out_valid is first seen high.
    task automatic wait_ov(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = out_valid;
        end
        if (!ok) fail_now("result_timeout");
    endtask

    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] em3, input logic edec);
        bit ok;
        send(a, b);
        wait_ov(ok);
        if (ok) begin
            check({name, "_m3"}, m3, em3);
            check({name, "_dec"}, decrement_exponent, edec);
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard / per-cycle compare.
    always @(negedge clk) begin
        if (reset) begin
            n_acc -= exp_q.size();
            exp_q.delete();
            prev_ov    = 1'b0;
            prev_taken = 1'b0;
        end else begin
            check("busy_vs_in_ready", busy, !in_ready);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("spurious_out_valid");
                end else begin
                    check("m3", m3, exp_q[0].m3);
                    check("decrement_exponent", decrement_exponent, exp_q[0].dec);
                    if (!prev_ov) check("latency", cyc, exp_q[0].t + W + 1);
                end
                if (prev_ov && !prev_taken) begin
                    check("hold_m3", m3, prev_m3);
                    check("hold_dec", decrement_exponent, prev_dec);
                end
            end else if (prev_ov && !prev_taken) begin
                fail_now("out_valid_dropped");
            end
            prev_ov    = out_valid;
            prev_taken = out_valid && out_ready;
            prev_m3    = m3;
            prev_dec   = decrement_exponent;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                n_res++;
            end
            if (in_valid && in_ready) begin
                {e.dec, e.m3} = ref_div(m1, m2);
                e.t = cyc + 1;
                exp_q.push_back(e);
                n_acc++;
            end
        end
    end

    initial begin
        bit ok;
        logic [W:0] r;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_m3", m3, 0);
        check("rst_dec", decrement_exponent, 1'b0);

        check("model_1_1", ref_div(23'h000000, 23'h000000), {1'b0, 23'h000000});
        check("model_1_1p5", ref_div(23'h000000, 23'h400000), {1'b1, 23'h2AAAAA});
        check("model_1p5_1", ref_div(23'h400000, 23'h000000), {1'b0, 23'h400000});
        check("model_max_max", ref_div(23'h7FFFFF, 23'h7FFFFF), {1'b0, 23'h000000});

        @(posedge clk);
        #1 out_ready = 1'b1;
        directed("one_one", 23'h000000, 23'h000000, 23'h000000, 1'b0);
        directed("one_1p5", 23'h000000, 23'h400000, 23'h2AAAAA, 1'b1);
        directed("1p5_one", 23'h400000, 23'h000000, 23'h400000, 1'b0);
        directed("max_max", 23'h7FFFFF, 23'h7FFFFF, 23'h000000, 1'b0);

        // Backpressure: result held for 10 cycles while a new request waits.
        out_ready = 1'b0;
        send(23'h123456, 23'h654321);
        r = ref_div(23'h123456, 23'h654321);
        wait_ov(ok);
        in_valid = 1'b1;
        m1 = 23'h0ABCDE;
        m2 = 23'h31337F;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_m3", m3, r[W-1:0]);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_after_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_ov(ok);
        @(posedge clk);
        #1;

        // Reset in the middle of CALC discards the operation.
        send(23'h400000, 23'h000000);
        repeat (11) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        directed("post_rst", 23'h400000, 23'h000000, 23'h400000, 1'b0);

        // Random back-to-back traffic with random consumer stalls.
        fork
            begin
                for (int i = 0; i < NR; i++) begin
                    logic [W-1:0] a, b;
                    a = W'($urandom);
                    b = ($urandom_range(0, 9) == 0) ? a : W'($urandom);
                    send(a, b);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join

        out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0) && !busy;
        end
        if (!ok) fail_now("drain_timeout");
        check("results_per_accept", n_res, n_acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
